// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults, queue entry layout and response classification for the fetch queue.
package if_pkg;

  localparam int unsigned IF_ADDR_W   = 32;
  localparam int unsigned IF_DATA_W   = 32;
  localparam int unsigned IF_PC_INC   = 4;
  localparam int unsigned IF_RESET_PC = 0;

  typedef struct packed {
    logic [IF_DATA_W-1:0] instr;
    logic [IF_ADDR_W-1:0] pc_next;
  } if_entry_t;

  // What a given cycle's memory response does to the fetch state
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_PUSH,
    RESP_DROP,
    RESP_STRAY
  } if_resp_e;

  function automatic bit if_is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/response port plus the valid/ready port toward ID.
interface if_fetch_queue_if
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned DATA_W = IF_DATA_W
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              id_valid;
  logic [DATA_W-1:0] id_instruction;
  logic [ADDR_W-1:0] id_pc_next;
  logic              id_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_instruction, id_pc_next,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_instruction, id_pc_next,
    output id_ready
  );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous prefetch FIFO with a registered head word; clear empties it in one cycle.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned DATA_W = IF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_instr,
  input  logic [ADDR_W-1:0]      push_pc_next,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [DATA_W-1:0]      head_instr,
  output logic [ADDR_W-1:0]      head_pc_next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc_next;
  } entry_t;

  entry_t entry_mem [DEPTH];

  entry_t           head_reg, head_next, push_entry;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  always_comb begin
    push_entry  = '{instr: push_instr, pc_next: push_pc_next};
    // Upstream credit keeps push away from a full queue; the guard only protects the pointers
    do_push     = push && !clear && (count_reg != FULL_CNT);
    do_pop      = pop && !clear && (count_reg != '0);
    rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
    wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
    count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clear) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end

    // Head is read one cycle ahead; a push landing in the new head slot bypasses the array
    if (count_next == '0) begin
      head_next = '0;
    end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = push_entry;
    end else begin
      head_next = entry_mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      entry_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign head_valid   = (count_reg != '0);
  assign head_instr   = head_reg.instr;
  assign head_pc_next = head_reg.pc_next;
  assign count        = count_reg;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch unit: credit-limited instruction requests, in-order response tracking with
// stale-response dropping after redirects, and a prefetch queue toward ID.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IF_ADDR_W,
  parameter int unsigned       DATA_W   = IF_DATA_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
  parameter int unsigned       PC_INC   = IF_PC_INC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_taken,
  input  logic                   branch_taken,
  input  logic [ADDR_W-1:0]      pc_jump,
  input  logic [ADDR_W-1:0]      pc_branch,
  if_fetch_queue_if.master       bus,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   proto_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  if (!if_is_pow2(DEPTH)) begin : g_depth_check
    $error("if_fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0]  inflight_reg, inflight_next;
  logic [CNT_W-1:0]  drop_reg, drop_next;
  logic              proto_err_reg, proto_err_next;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [CNT_W:0]    credit_used;
  logic              req_int;
  logic              accept;
  logic              push;
  logic              pop;
  if_resp_e          resp_kind;

  always_comb begin
    redirect    = jump_taken | branch_taken;
    target      = jump_taken ? pc_jump : pc_branch;
    credit_used = {1'b0, q_count} + {1'b0, inflight_reg};
    req_int     = !redirect && (credit_used < CREDIT_MAX);
    accept      = req_int && bus.imem_gnt;

    resp_kind = RESP_NONE;
    if (bus.imem_rvalid) begin
      if (inflight_reg == '0) begin
        resp_kind = RESP_STRAY;
      end else if (redirect || (drop_reg != '0)) begin
        resp_kind = RESP_DROP;
      end else begin
        resp_kind = RESP_PUSH;
      end
    end

    push = (resp_kind == RESP_PUSH);
    pop  = bus.id_valid && bus.id_ready && !redirect;

    pc_next      = redirect ? target : (accept ? pc_reg + INC : pc_reg);
    resp_pc_next = redirect ? target : (push ? resp_pc_reg + INC : resp_pc_reg);

    inflight_next = inflight_reg;
    if (accept) begin
      inflight_next = inflight_next + CNT_W'(1);
    end
    if ((resp_kind == RESP_PUSH) || (resp_kind == RESP_DROP)) begin
      inflight_next = inflight_next - CNT_W'(1);
    end

    // On redirect every request still outstanding is stale, including ones already marked
    // for dropping, so the drop count is rebuilt from inflight rather than accumulated.
    drop_next = drop_reg;
    if (redirect) begin
      drop_next = inflight_reg - CNT_W'(resp_kind == RESP_DROP);
    end else if (resp_kind == RESP_DROP) begin
      drop_next = drop_reg - CNT_W'(1);
    end

    proto_err_next = proto_err_reg | (resp_kind == RESP_STRAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      resp_pc_reg   <= RESET_PC;
      inflight_reg  <= '0;
      drop_reg      <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      resp_pc_reg   <= resp_pc_next;
      inflight_reg  <= inflight_next;
      drop_reg      <= drop_next;
      proto_err_reg <= proto_err_next;
    end
  end

  if_fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear        (redirect),
    .push         (push),
    .push_instr   (bus.imem_rdata),
    .push_pc_next (resp_pc_reg + INC),
    .pop          (pop),
    .head_valid   (bus.id_valid),
    .head_instr   (bus.id_instruction),
    .head_pc_next (bus.id_pc_next),
    .count        (q_count)
  );

  assign bus.imem_req  = req_int;
  assign bus.imem_addr = pc_reg;
  assign proto_err     = proto_err_reg;

endmodule
